axis_tx_msix_mc_bridge: RTL and testbench

- Multi-channel successor to the single-function MSI-X Tx bridge.
- Accepts MSI-X vector strobes from NUM_CH independent requesters (PFs/VFs or engines), buffers each in its own FIFO, and round-robin arbitrates onto one PCIe SS AXI-S Tx source as single-beat DM_INTR headers.
- Sits between interrupt sources and the Tx mux feeding the PCIe subsystem.
- Adds per-channel function mapping, per-channel backpressure, overflow detection and fair arbitration.

---
 rtl/msix_bridge_pkg.sv | 17 +
 rtl/pcie_ss_hdr_pkg.sv | 21 ++
 rtl/pcie_ss_axis_if.sv | 24 ++
 rtl/msix_ch_fifo.sv | 82 ++++++++
 rtl/axis_tx_msix_mc_bridge.sv | 147 ++++++++++++++
 tb/tb_axis_tx_msix_mc_bridge.sv | 259 +++++++++++++++++++++++++
 6 files changed

// File: rtl/msix_bridge_pkg.sv
// Shared types for the multi-channel MSI-X Tx bridge.
package msix_bridge_pkg;

    localparam int FUNC_W = 15;

    typedef struct packed {
        logic        vf_active;
        logic [10:0] vf_num;
        logic [2:0]  pf_num;
    } ch_func_t;

    typedef struct packed {
        ch_func_t    func;
        logic [15:0] vector;
    } msix_entry_t;

endpackage

// File: rtl/pcie_ss_hdr_pkg.sv
// PCIe SS Tx header types used by the interrupt bridges.
// Interrupt header occupies tdata[255:0]; upper beat bits stay zero.
package pcie_ss_hdr_pkg;

    localparam int TDATA_W = 512;
    localparam int TUSER_W = 10;

    localparam logic [7:0] DM_INTR = 8'h30;

    typedef struct packed {
        logic [191:0] rsvd_hi;
        logic [15:0]  vector_num;
        logic         vf_active;
        logic [10:0]  vf_num;
        logic [2:0]   pf_num;
        logic         rsvd_pf;
        logic [23:0]  rsvd_lo;
        logic [7:0]   fmt_type;
    } PCIe_IntrHdr_t;

endpackage

// File: rtl/pcie_ss_axis_if.sv
// PCIe SS AXI-S stream bundle with source/sink views.
interface pcie_ss_axis_if #(
    parameter int DATA_W = 512,
    parameter int USER_W = 10
) ();

    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [DATA_W/8-1:0] tkeep;
    logic              tlast;
    logic [USER_W-1:0] tuser_vendor;

    modport source (
        output tvalid, tdata, tkeep, tlast, tuser_vendor,
        input  tready
    );

    modport sink (
        input  tvalid, tdata, tkeep, tlast, tuser_vendor,
        output tready
    );

endinterface

// File: rtl/msix_ch_fifo.sv
// Per-channel showahead FIFO of MSI-X entries with overflow drop.
// MSIX_DUP_FILTER_EN: discard a push equal to the still-queued tail.
module msix_ch_fifo
    import msix_bridge_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  msix_entry_t              din,
    input  logic                     pop,
    output msix_entry_t              dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   cnt_nxt,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    msix_entry_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          dup;
    logic          accept;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

`ifdef MSIX_DUP_FILTER_EN
    msix_entry_t last_q;
    logic        last_vld;

    // The tail is the most recent push for as long as the FIFO holds it
    assign dup = last_vld && (din == last_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_vld <= 1'b0;
            last_q   <= '0;
        end else if (accept) begin
            last_vld <= 1'b1;
            last_q   <= din;
        end else if (pop && count == CW'(1)) begin
            last_vld <= 1'b0;
        end
    end
`else
    assign dup = 1'b0;
`endif

    assign accept  = push && !dup && (!full || pop);
    assign drop    = push && !dup && full && !pop;
    assign cnt_nxt = count + CW'(accept) - CW'(pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= cnt_nxt;
        end
    end

endmodule

// File: rtl/axis_tx_msix_mc_bridge.sv
// Multi-channel MSI-X strobes -> round-robin DM_INTR headers on PCIe SS Tx.
// Optional MSIX_DUP_FILTER_EN drops repeats of a channel's queued tail.
module axis_tx_msix_mc_bridge
    import msix_bridge_pkg::*;
    import pcie_ss_hdr_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int VEC_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    pcie_ss_axis_if.source          axis_tx_if,
    input  logic [NUM_CH-1:0]       msix_strb,
    input  logic [NUM_CH*VEC_W-1:0] msix_num,
    input  logic [NUM_CH*FUNC_W-1:0] ch_func,
    output logic [NUM_CH-1:0]       msix_ready,
    output logic [NUM_CH-1:0]       ovf_sticky,
    output logic [NUM_CH-1:0]       pending,
    output logic                    axis_tx_error
);

    localparam int CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0] strb_q;
    msix_entry_t       in_q [NUM_CH];
    msix_entry_t       head [NUM_CH];
    logic [CW-1:0]     cnt_nxt [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] pop;

    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt;
    logic              any;
    logic              load;
    int                idx;

    logic              tvalid_q;
    msix_entry_t       ent_q;
    PCIe_IntrHdr_t     hdr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                in_q[c] <= '0;
            end
        end else begin
            strb_q <= msix_strb;
            for (int c = 0; c < NUM_CH; c++) begin
                in_q[c].func   <= ch_func_t'(ch_func[c*FUNC_W +: FUNC_W]);
                in_q[c].vector <= 16'(msix_num[c*VEC_W +: VEC_W]);
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        msix_ch_fifo #(
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (strb_q[c]),
            .din     (in_q[c]),
            .pop     (pop[c]),
            .dout    (head[c]),
            .empty   (empty[c]),
            .cnt_nxt (cnt_nxt[c]),
            .drop    (drop[c])
        );
    end

    // Descending scan so the channel closest to rr_ptr wins
    always_comb begin
        gnt = rr_ptr;
        any = 1'b0;
        idx = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!empty[idx]) begin
                gnt = CH_W'(idx);
                any = 1'b1;
            end
        end
    end

    assign load = any && (!tvalid_q || axis_tx_if.tready);

    always_comb begin
        pop = '0;
        if (load) begin
            pop[gnt] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tvalid_q <= 1'b0;
            ent_q    <= '0;
            rr_ptr   <= '0;
        end else if (load) begin
            tvalid_q <= 1'b1;
            ent_q    <= head[gnt];
            rr_ptr   <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + 1'b1;
        end else if (axis_tx_if.tready) begin
            tvalid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msix_ready    <= '0;
            ovf_sticky    <= '0;
            axis_tx_error <= 1'b0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                msix_ready[c] <= (cnt_nxt[c] <= CW'(FIFO_DEPTH - 3));
            end
            ovf_sticky    <= ovf_sticky | drop;
            axis_tx_error <= |drop;
        end
    end

    assign pending = ~empty;

    always_comb begin
        hdr            = '0;
        hdr.fmt_type   = DM_INTR;
        hdr.pf_num     = ent_q.func.pf_num;
        hdr.vf_num     = ent_q.func.vf_num;
        hdr.vf_active  = ent_q.func.vf_active;
        hdr.vector_num = ent_q.vector;
    end

    assign axis_tx_if.tvalid       = tvalid_q;
    assign axis_tx_if.tdata        =
        {{(TDATA_W - $bits(PCIe_IntrHdr_t)){1'b0}}, hdr};
    assign axis_tx_if.tkeep        = '1;
    assign axis_tx_if.tlast        = tvalid_q;
    assign axis_tx_if.tuser_vendor = tvalid_q ? 10'h1 : 10'h0;

endmodule

// File: tb/tb_axis_tx_msix_mc_bridge.sv
// Directed bench for axis_tx_msix_mc_bridge (4 ch, depth 16).
// Build with +define+MSIX_DUP_FILTER_EN to cover the duplicate filter.
module tb_axis_tx_msix_mc_bridge;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  strb;
    logic [63:0] num;
    logic [59:0] fn;
    logic [3:0]  rdy;
    logic [3:0]  ovf;
    logic [3:0]  pend;
    logic        err;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    logic bad;

    pcie_ss_axis_if tx ();

    axis_tx_msix_mc_bridge dut (
        .clk           (clk),
        .rst           (rst),
        .axis_tx_if    (tx),
        .msix_strb     (strb),
        .msix_num      (num),
        .ch_func       (fn),
        .msix_ready    (rdy),
        .ovf_sticky    (ovf),
        .pending       (pend),
        .axis_tx_error (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err === 1'b1) err_cnt++;
    end

    // Hand-packed DM_INTR header: fmt[7:0] pf[35:33] vf[46:36] vfa[47] vec[63:48]
    function automatic logic [511:0] hdr(input logic [2:0] pf,
                                         input logic [10:0] vf,
                                         input logic vfa,
                                         input logic [15:0] vec);
        logic [511:0] h;
        h = '0;
        h[7:0]   = 8'h30;
        h[35:33] = pf;
        h[46:36] = vf;
        h[47]    = vfa;
        h[63:48] = vec;
        return h;
    endfunction

    task automatic check(input string tag, input logic [511:0] obs,
                         input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setch(input int c, input logic [15:0] v,
                         input logic [2:0] pf, input logic [10:0] vf,
                         input logic vfa);
        num[c*16 +: 16] = v;
        fn[c*15 +: 15]  = {vfa, vf, pf};
        strb[c]         = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        strb = '0;
        tx.tready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        err_cnt = 0;
    endtask

    task automatic beat(input string tag, input logic [511:0] exp);
        check({tag, "_tvalid"}, tx.tvalid, 1'b1);
        check({tag, "_tdata"}, tx.tdata, exp);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        strb = '0;
        num = '0;
        fn = '0;
        tx.tready = 1'b0;
        #1;
        check("rst_tvalid", tx.tvalid, 1'b0);
        check("rst_tlast", tx.tlast, 1'b0);
        check("rst_tuser", tx.tuser_vendor, 10'h0);
        check("rst_ready", rdy, 4'h0);
        check("rst_ovf", ovf, 4'h0);
        check("rst_pend", pend, 4'h0);
        check("rst_err", err, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("ready_after_rst", rdy, 4'hF);

        // single strobe, two edges from capture to tvalid
        tx.tready = 1'b1;
        setch(0, 16'h0005, 3'd2, 11'd0, 1'b0);
        tick();
        strb = '0;
        check("s1_lat1", tx.tvalid, 1'b0);
        tick();
        check("s1_lat2", tx.tvalid, 1'b0);
        check("s1_pend", pend, 4'b0001);
        tick();
        check("s1_tvalid", tx.tvalid, 1'b1);
        check("s1_tdata", tx.tdata, hdr(3'd2, 11'd0, 1'b0, 16'h5));
        check("s1_tuser", tx.tuser_vendor, 10'h1);
        check("s1_tlast", tx.tlast, 1'b1);
        check("s1_tkeep", tx.tkeep, {64{1'b1}});
        check("s1_pend0", pend, 4'b0000);
        tick();
        check("s1_done", tx.tvalid, 1'b0);

        // simultaneous burst, pointer from 0
        do_reset();
        tx.tready = 1'b1;
        for (int c = 0; c < 4; c++)
            setch(c, 16'h0010 + 16'(c), 3'(c), 11'(c * 3), c == 3);
        tick();
        strb = '0;
        tick();
        tick();
        for (int c = 0; c < 4; c++)
            beat("b1", hdr(3'(c), 11'(c * 3), c == 3, 16'h0010 + 16'(c)));
        check("b1_gap", tx.tvalid, 1'b0);
        for (int c = 0; c < 4; c++)
            setch(c, 16'h0020 + 16'(c), 3'(c), 11'd0, 1'b0);
        tick();
        strb = '0;
        tick();
        tick();
        for (int c = 0; c < 4; c++)
            beat("b2", hdr(3'(c), 11'd0, 1'b0, 16'h0020 + 16'(c)));
        check("b2_gap", tx.tvalid, 1'b0);

        // ch2 alone moves pointer to 3, then ch3 beats ch0
        setch(2, 16'h0042, 3'd2, 11'd0, 1'b0);
        tick();
        strb = '0;
        tick();
        tick();
        beat("rr_c2", hdr(3'd2, 11'd0, 1'b0, 16'h0042));
        setch(0, 16'h0050, 3'd0, 11'd0, 1'b0);
        setch(3, 16'h0053, 3'd3, 11'd0, 1'b0);
        tick();
        strb = '0;
        tick();
        tick();
        beat("rr_c3", hdr(3'd3, 11'd0, 1'b0, 16'h0053));
        beat("rr_c0", hdr(3'd0, 11'd0, 1'b0, 16'h0050));
        check("rr_gap", tx.tvalid, 1'b0);

        // backpressure and overflow on ch1
        do_reset();
        bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            setch(1, 16'h0100 + 16'(k), 3'd1, 11'd5, 1'b1);
            tick();
            if (k == 14) check("bp_ready_13", rdy[1], 1'b1);
            if (k == 15) check("bp_ready_14", rdy[1], 1'b0);
            if (k >= 2 && (tx.tvalid !== 1'b1 ||
                tx.tdata !== hdr(3'd1, 11'd5, 1'b1, 16'h0100)))
                bad = 1'b1;
        end
        strb = '0;
        tick();
        tick();
        tick();
        check("bp_stable", bad, 1'b0);
        check("bp_err_cycles", err_cnt, 3);
        check("bp_ovf", ovf, 4'b0010);
        check("bp_pend", pend, 4'b0010);
        tx.tready = 1'b1;
        for (int i = 0; i <= 16; i++)
            beat("bp_drain", hdr(3'd1, 11'd5, 1'b1, 16'h0100 + 16'(i)));
        check("bp_end", tx.tvalid, 1'b0);
        check("bp_pend0", pend, 4'b0000);
        check("bp_ovf_hold", ovf, 4'b0010);
        check("bp_ready_back", rdy[1], 1'b1);

        // reset while a header is held and three are queued
        do_reset();
        for (int c = 0; c < 4; c++)
            setch(c, 16'h0200 + 16'(c), 3'(c), 11'd0, 1'b0);
        tick();
        strb = '0;
        tick();
        tick();
        check("mr_tvalid", tx.tvalid, 1'b1);
        check("mr_pend", pend, 4'b1110);
        #3;
        rst = 1'b1;
        #1;
        check("mr_drop", tx.tvalid, 1'b0);
        check("mr_pend_clr", pend, 4'b0000);
        tick();
        rst = 1'b0;
        tx.tready = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (tx.tvalid !== 1'b0) bad = 1'b1;
        end
        check("mr_no_stale", bad, 1'b0);
        check("mr_pend_after", pend, 4'b0000);
        check("mr_ovf", ovf, 4'b0000);

        // repeated vector 7 on ch2 behind a held ch0 header
        do_reset();
        setch(0, 16'h0055, 3'd0, 11'd0, 1'b0);
        tick();
        strb = '0;
        tick();
        tick();
        check("dup_hold", tx.tvalid, 1'b1);
        setch(2, 16'h0007, 3'd2, 11'd0, 1'b0);
        tick();
        tick();
        tick();
        strb = '0;
        tick();
        tick();
        check("dup_pend", pend, 4'b0100);
        tx.tready = 1'b1;
        beat("dup_c0", hdr(3'd0, 11'd0, 1'b0, 16'h0055));
`ifdef MSIX_DUP_FILTER_EN
        beat("dup_v7", hdr(3'd2, 11'd0, 1'b0, 16'h0007));
`else
        for (int i = 0; i < 3; i++)
            beat("dup_v7", hdr(3'd2, 11'd0, 1'b0, 16'h0007));
`endif
        check("dup_end", tx.tvalid, 1'b0);
        check("dup_ovf", ovf, 4'b0000);
        check("dup_err", err_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
